alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv.sv | 108 ++++++++++
 rtl/alu_mc.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and mult/div FSM states for the multi-cycle ALU.
package alu_pkg;
  localparam logic [3:0] OP_MOVB = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_ADD4 = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_SLT  = 4'hD;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int SIGN_SUB    = 0;
  localparam int SIGN_SIGNED = 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdState_t;
endpackage

// File: rtl/alu_muldiv.sv
// Radix-2 shift-add multiplier / restoring divider: 1 load cycle, WIDTH iterations, 1 sign-fix cycle.
// Results are presented combinationally while in FIX; start is only honoured in IDLE.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isDiv,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             lastIter,
  output logic             fixVld,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo,
  output logic             divZero
);
  localparam int CW = $clog2(WIDTH);

  mdState_t state, stateNext;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, mcand, aOrig;
  logic             divMode, negQ, negR, dz;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   addSum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  assign magA    = (isSigned && opA[WIDTH-1]) ? -opA : opA;
  assign magB    = (isSigned && opB[WIDTH-1]) ? -opB : opB;
  assign addSum  = {1'b0, hi} + {1'b0, mcand};
  assign shifted = {hi, lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};
  assign prod    = negQ ? -{hi, lo} : {hi, lo};
  assign divZero = dz;

  always_comb begin
    stateNext = state;
    lastIter  = 1'b0;
    fixVld    = 1'b0;
    case (state)
      IDLE: if (start) stateNext = RUN;
      RUN: begin
        if (cnt == CW'(WIDTH-1)) begin
          lastIter  = 1'b1;
          stateNext = FIX;
        end
      end
      FIX: begin
        fixVld    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    resHi = prod[2*WIDTH-1:WIDTH];
    resLo = prod[WIDTH-1:0];
    if (dz) begin
      resHi = aOrig;
      resLo = '1;
    end else if (divMode) begin
      resHi = negR ? -hi : hi;
      resLo = negQ ? -lo : lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; hi <= '0; lo <= '0; mcand <= '0; aOrig <= '0;
      divMode <= 1'b0; negQ <= 1'b0; negR <= 1'b0; dz <= 1'b0;
    end else if (state == IDLE && start) begin
      // Divide keeps the dividend in lo and shifts it into hi; multiply keeps the multiplier in lo.
      cnt     <= '0;
      hi      <= '0;
      lo      <= isDiv ? magA : magB;
      mcand   <= isDiv ? magB : magA;
      aOrig   <= opA;
      divMode <= isDiv;
      dz      <= isDiv && (opB == '0);
      negQ    <= isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      negR    <= isDiv && isSigned && opA[WIDTH-1];
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (divMode) begin
        if (!diff[WIDTH]) begin
          hi <= diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= shifted[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else if (lo[0]) begin
        {hi, lo} <= {addSum, lo[WIDTH-1:1]};
      end else begin
        {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish one edge after accept, mult/div WIDTH+2 edges after accept.
// start is ignored while busy; a start coinciding with done is accepted.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [1:0]       sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic [3:0]       carryFlag,
  output logic             divzero
);
  logic             accept, pending, isMd;
  logic [3:0]       opReg;
  logic [1:0]       signReg;
  logic [WIDTH-1:0] aReg, bReg, bOp, sum, yNext, sraRes;
  logic [WIDTH:0]   addRes;
  logic [SHW-1:0]   shamt;
  logic [3:0]       flagsNext;
  logic             yWr, ltRes;
  logic             mdLast, mdFix, mdDz;
  logic [WIDTH-1:0] mdHi, mdLo;

  assign accept = start && !busy;
  assign isMd   = (opReg == OP_MUL) || (opReg == OP_DIV);
  assign shamt  = aReg[SHW-1:0];
  assign sraRes = $signed(bReg) >>> shamt;

  always_comb begin
    bOp    = signReg[SIGN_SUB] ? ~bReg : bReg;
    addRes = {1'b0, aReg} + {1'b0, bOp} + {{WIDTH{1'b0}}, signReg[SIGN_SUB]};
    sum    = addRes[WIDTH-1:0];
    ltRes  = signReg[SIGN_SIGNED] ? ($signed(aReg) < $signed(bReg)) : (aReg < bReg);
    flagsNext         = '0;
    flagsNext[FLAG_C] = addRes[WIDTH];
    flagsNext[FLAG_Z] = (sum == '0);
    flagsNext[FLAG_N] = sum[WIDTH-1];
    flagsNext[FLAG_V] = signReg[SIGN_SIGNED] && (aReg[WIDTH-1] == bOp[WIDTH-1])
                        && (sum[WIDTH-1] != aReg[WIDTH-1]);
    yNext = Y;
    yWr   = 1'b1;
    case (opReg)
      OP_MOVB: yNext = bReg;
      OP_ADD:  yNext = sum;
      OP_AND:  yNext = aReg & bReg;
      OP_OR:   yNext = aReg | bReg;
      OP_NOR:  yNext = ~(aReg | bReg);
      OP_SRL:  yNext = bReg >> shamt;
      OP_SLL:  yNext = bReg << shamt;
      OP_SRA:  yNext = sraRes;
      OP_LUI:  yNext = {bReg[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_ADD4: yNext = bReg + WIDTH'(4);
      OP_XOR:  yNext = aReg ^ bReg;
      OP_SLT:  yNext = {{(WIDTH-1){1'b0}}, ltRes};
      default: yWr   = 1'b0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) uMulDiv (
    .clk      (clk),
    .reset    (reset),
    .start    (pending && isMd),
    .isDiv    (opReg == OP_DIV),
    .isSigned (signReg[SIGN_SIGNED]),
    .opA      (aReg),
    .opB      (bReg),
    .lastIter (mdLast),
    .fixVld   (mdFix),
    .resHi    (mdHi),
    .resLo    (mdLo),
    .divZero  (mdDz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0; opReg <= '0; signReg <= '0; aReg <= '0; bReg <= '0;
      busy <= 1'b0; done <= 1'b0; divzero <= 1'b0;
      Y <= '0; outHI <= '0; outLO <= '0; carryFlag <= '0;
    end else begin
      done    <= 1'b0;
      pending <= accept;
      if (accept) begin
        opReg   <= operation;
        signReg <= sign;
        aReg    <= A;
        bReg    <= B;
        divzero <= 1'b0;
        if (operation == OP_MUL || operation == OP_DIV) busy <= 1'b1;
      end
      // busy drops as the engine enters FIX so a start can land on the done edge.
      if (mdLast) busy <= 1'b0;
      if (pending && !isMd) begin
        done <= 1'b1;
        if (yWr) Y <= yNext;
        if (opReg == OP_ADD) carryFlag <= flagsNext;
      end
      if (mdFix) begin
        done    <= 1'b1;
        outHI   <= mdHi;
        outLO   <= mdLo;
        divzero <= mdDz;
      end
    end
  end
endmodule
